// File: rtl/wb_reg_responder.sv
`default_nettype none
// ============================================================================
// wb_reg_responder
// Wishbone-classic 8-bit register slave with WAIT_STATES extra ack latency.
// Optional reload timer and interrupt, built only when WB_RESP_TIMER_EN is defined.
// Revision: 1.0
// ============================================================================
module wb_reg_responder #(
  parameter int         WAIT_STATES = 0,
  parameter logic [7:0] ID_VALUE    = 8'hA5
) (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  input  logic [2:0] wb_addr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_we_i,
  input  logic       wb_stb_i,
  input  logic       wb_cyc_i,
  output logic       wb_ack_o,
  output logic       wb_inta_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;
  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  logic [1:0] state;
  logic [1:0] state_nx;
  logic [2:0] wait_cnt;
  logic [2:0] addr_q;
  logic       we_q;
  logic [7:0] wdat_q;
  logic       req;
  logic       commit;
  logic       wr_en;
  logic [7:0] rdata;
  logic [7:0] scratch0;
  logic [7:0] scratch1;
  logic [7:0] ctrl;
  logic [7:0] reload;
  logic [7:0] access_cnt;
  logic [7:0] count;
  logic       if_flag;
  logic       inta;

  assign req = wb_cyc_i & wb_stb_i;

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (req) state_nx = (WAIT_STATES > 0) ? ST_WAIT : ST_ACK;
      ST_WAIT: begin
        if (!req)                  state_nx = ST_IDLE;
        else if (wait_cnt == 3'd0) state_nx = ST_ACK;
      end
      ST_ACK:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // ACK's exit edge raises the registered ack, commits the write and captures read data.
  always_comb begin
    commit = (state == ST_ACK);
    wr_en  = commit & we_q;
    rdata  = 8'h00;
    case (addr_q)
      3'd0: rdata = scratch0;
      3'd1: rdata = scratch1;
      3'd2: rdata = ctrl;
      3'd3: rdata = {7'b0, if_flag};
      3'd4: rdata = reload;
      3'd5: rdata = count;
      3'd6: rdata = ID_VALUE;
      3'd7: rdata = access_cnt;
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      addr_q   <= 3'd0;
      we_q     <= 1'b0;
      wdat_q   <= 8'h00;
      wait_cnt <= 3'd0;
    end else begin
      if (state == ST_IDLE && req) begin
        addr_q   <= wb_addr_i;
        we_q     <= wb_we_i;
        wdat_q   <= wb_dat_i;
        wait_cnt <= WAIT_LOAD;
      end else if (state == ST_WAIT && wait_cnt != 3'd0) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      scratch0   <= 8'h00;
      scratch1   <= 8'h00;
      ctrl       <= 8'h00;
      reload     <= 8'h00;
      access_cnt <= 8'h00;
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= 8'h00;
    end else begin
      wb_ack_o <= commit;
      wb_dat_o <= commit ? rdata : 8'h00;
      if (commit) access_cnt <= access_cnt + 8'd1;
      if (wr_en) begin
        case (addr_q)
          3'd0:    scratch0 <= wdat_q;
          3'd1:    scratch1 <= wdat_q;
          3'd2:    ctrl     <= wdat_q;
          3'd4:    reload   <= wdat_q;
          default: ;
        endcase
      end
    end
  end

`ifdef WB_RESP_TIMER_EN
  logic ten_d;
  logic if_set;
  logic if_clr;

  assign if_set = ctrl[1] & ten_d & (count == 8'd0);
  assign if_clr = wr_en & (addr_q == 3'd3) & wdat_q[0];

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      ten_d   <= 1'b0;
      count   <= 8'h00;
      if_flag <= 1'b0;
      inta    <= 1'b0;
    end else begin
      ten_d <= ctrl[1];
      // A fresh TEN rising edge loads from RELOAD just like an expiry does.
      if (ctrl[1]) begin
        if (!ten_d || count == 8'd0) count <= reload;
        else                         count <= count - 8'd1;
      end
      if (if_set)      if_flag <= 1'b1;
      else if (if_clr) if_flag <= 1'b0;
      inta <= if_flag & ctrl[0];
    end
  end
`else
  assign count   = 8'h00;
  assign if_flag = 1'b0;
  assign inta    = 1'b0;
`endif

  assign wb_inta_o = inta;

endmodule
`default_nettype wire
